// File: rtl/health_bank_if.sv
// Handshake-free control/status bundle for the health bank.
// Master drives requests and the decay period; slave reports per-channel health.
interface health_bank_if #(
  parameter int NUM_CH   = 2,
  parameter int HEALTH_W = 7,
  parameter int RATE_W   = 27
);
  logic                         enable;
  logic [RATE_W-1:0]            health_rate;
  logic [NUM_CH-1:0]            add_valid;
  logic [NUM_CH*HEALTH_W-1:0]   add_amount;
  logic [NUM_CH-1:0]            revive;
  logic [NUM_CH*HEALTH_W-1:0]   current_health;
  logic [NUM_CH-1:0]            no_health;
  logic [NUM_CH-1:0]            critical;
  logic                         all_dead;
  logic                         game_over;

  modport master (
    output enable, health_rate, add_valid, add_amount, revive,
    input  current_health, no_health, critical, all_dead, game_over
  );

  modport slave (
    input  enable, health_rate, add_valid, add_amount, revive,
    output current_health, no_health, critical, all_dead, game_over
  );
endinterface

// File: rtl/health_bank.sv
// Bank of independent health counters sharing one decay prescaler.
// Channels saturate at MAX_HEALTH and latch DEAD at zero until revived.
module health_bank #(
  parameter int NUM_CH      = 2,
  parameter int HEALTH_W    = 7,
  parameter int RATE_W      = 27,
  parameter int INIT_HEALTH = 20,
  parameter int MAX_HEALTH  = 99,
  parameter int CRIT_LEVEL  = 5
) (
  input  logic         clk,
  input  logic         reset,
  health_bank_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ALIVE,
    ST_CRIT,
    ST_DEAD
  } ch_state_e;

  localparam int EW = HEALTH_W + 2;
  localparam logic [EW-1:0] MAX_E = EW'(MAX_HEALTH);
  localparam logic [HEALTH_W-1:0] INIT_H = HEALTH_W'(INIT_HEALTH);
  localparam logic [HEALTH_W-1:0] CRIT_H = HEALTH_W'(CRIT_LEVEL);
  localparam ch_state_e INIT_ST =
    (INIT_HEALTH > CRIT_LEVEL) ? ST_ALIVE : ST_CRIT;

  function automatic ch_state_e classify(
    input logic [HEALTH_W-1:0] h
  );
    if (h == '0)
      return ST_DEAD;
    else if (h <= CRIT_H)
      return ST_CRIT;
    else
      return ST_ALIVE;
  endfunction

  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic              tick;

  logic [NUM_CH-1:0][HEALTH_W-1:0] health_q, health_d;
  ch_state_e state_q [NUM_CH];
  ch_state_e state_d [NUM_CH];

  logic [NUM_CH-1:0] no_health_q, no_health_d;
  logic [NUM_CH-1:0] critical_q, critical_d;
  logic              all_dead_q, all_dead_d;
  logic              game_over_q, game_over_d;

  // A rate lowered below the running count fires on the next enabled cycle.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (bus.enable) begin
      if (cnt_q >= bus.health_rate) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + RATE_W'(1);
      end
    end
  end

  always_comb begin
    logic [EW-1:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      health_d[i] = health_q[i];
      state_d[i]  = state_q[i];
      sum = {2'b00, health_q[i]};
      if (bus.add_valid[i])
        sum = sum + {2'b00, bus.add_amount[i*HEALTH_W +: HEALTH_W]};
      if (tick && (sum != '0))
        sum = sum - EW'(1);
      if (sum > MAX_E)
        sum = MAX_E;
      if (bus.revive[i]) begin
        health_d[i] = INIT_H;
        state_d[i]  = INIT_ST;
      end else if (state_q[i] == ST_DEAD) begin
        health_d[i] = '0;
      end else begin
        health_d[i] = sum[HEALTH_W-1:0];
        state_d[i]  = classify(sum[HEALTH_W-1:0]);
      end
    end
  end

  always_comb begin
    no_health_d = '0;
    critical_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      no_health_d[i] = (state_d[i] == ST_DEAD);
      critical_d[i]  = (state_d[i] == ST_CRIT);
    end
    all_dead_d  = &no_health_d;
    game_over_d = all_dead_d & ~all_dead_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      no_health_q <= '0;
      critical_q  <= {NUM_CH{INIT_ST == ST_CRIT}};
      all_dead_q  <= 1'b0;
      game_over_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        health_q[i] <= INIT_H;
        state_q[i]  <= INIT_ST;
      end
    end else begin
      cnt_q       <= cnt_d;
      no_health_q <= no_health_d;
      critical_q  <= critical_d;
      all_dead_q  <= all_dead_d;
      game_over_q <= game_over_d;
      health_q    <= health_d;
      state_q     <= state_d;
    end
  end

  assign bus.current_health = health_q;
  assign bus.no_health      = no_health_q;
  assign bus.critical       = critical_q;
  assign bus.all_dead       = all_dead_q;
  assign bus.game_over      = game_over_q;

endmodule

// File: tb/tb_health_bank.sv
// Randomized bench for health_bank against an integer reference model.
// Directed phases walk decay, saturation, revive, freeze and reset cases.
module tb_health_bank;
  localparam int NC   = 2;
  localparam int HW   = 7;
  localparam int RW   = 27;
  localparam int INIT = 20;
  localparam int MAXH = 99;
  localparam int CRIT = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  health_bank_if #(.NUM_CH(NC), .HEALTH_W(HW), .RATE_W(RW)) bus ();

  health_bank dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int mh [NC];
  bit md [NC];
  int mcnt;
  bit mall;
  bit mgo;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit tk;
    bit alln;
    int v;
    if (rst) begin
      mcnt = 0;
      for (int i = 0; i < NC; i++) begin
        mh[i] = INIT;
        md[i] = 1'b0;
      end
      mall = 1'b0;
      mgo  = 1'b0;
      return;
    end
    tk = bus.enable && (mcnt >= int'(bus.health_rate));
    if (bus.enable)
      mcnt = tk ? 0 : mcnt + 1;
    for (int i = 0; i < NC; i++) begin
      if (bus.revive[i]) begin
        mh[i] = INIT;
        md[i] = 1'b0;
      end else if (md[i]) begin
        mh[i] = 0;
      end else begin
        v = mh[i];
        if (bus.add_valid[i])
          v += int'(bus.add_amount[i*HW +: HW]);
        if (tk)
          v -= 1;
        if (v < 0) v = 0;
        if (v > MAXH) v = MAXH;
        mh[i] = v;
        if (v == 0) md[i] = 1'b1;
      end
    end
    alln = 1'b1;
    for (int i = 0; i < NC; i++)
      if (!md[i]) alln = 1'b0;
    mgo  = alln && !mall;
    mall = alln;
  endfunction

  task automatic compare();
    bit ec;
    for (int i = 0; i < NC; i++) begin
      ec = !md[i] && (mh[i] > 0) && (mh[i] <= CRIT);
      check($sformatf("health%0d", i),
            32'(bus.current_health[i*HW +: HW]), 32'(mh[i]));
      check($sformatf("no_health%0d", i),
            32'(bus.no_health[i]), 32'(md[i]));
      check($sformatf("critical%0d", i),
            32'(bus.critical[i]), 32'(ec));
    end
    check("all_dead", 32'(bus.all_dead), 32'(mall));
    check("game_over", 32'(bus.game_over), 32'(mgo));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic set_add(input int ch, input int amt);
    bus.add_valid[ch] = 1'b1;
    bus.add_amount[ch*HW +: HW] = HW'(amt);
  endtask

  task automatic clr_in();
    bus.add_valid  = '0;
    bus.add_amount = '0;
    bus.revive     = '0;
  endtask

  int go_cnt;

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.health_rate = RW'(3);
    clr_in();
    step();
    rst = 1'b0;
    check("rst_h0", 32'(bus.current_health[0 +: HW]), 32'(INIT));
    check("rst_h1", 32'(bus.current_health[HW +: HW]), 32'(INIT));

    // Free-running decay to death of every channel.
    bus.enable = 1'b1;
    go_cnt = 0;
    repeat (100) begin
      step();
      if (bus.game_over === 1'b1) go_cnt++;
    end
    check("go_once", 32'(go_cnt), 32'd1);
    check("dead_all", 32'(bus.all_dead), 32'd1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rerst_h1", 32'(bus.current_health[HW +: HW]), 32'(INIT));

    // Saturation with a same-cycle tick, then net-zero add at h=2.
    bus.enable = 1'b0;
    set_add(0, 78);
    step();
    clr_in();
    check("h98", 32'(bus.current_health[0 +: HW]), 32'd98);
    bus.enable = 1'b1;
    bus.health_rate = RW'(0);
    set_add(0, 7);
    step();
    clr_in();
    check("sat99", 32'(bus.current_health[0 +: HW]), 32'd99);
    bus.enable = 1'b0;
    bus.revive[0] = 1'b1;
    step();
    clr_in();
    bus.enable = 1'b1;
    repeat (18) step();
    check("h2", 32'(bus.current_health[0 +: HW]), 32'd2);
    set_add(0, 1);
    step();
    clr_in();
    check("net2", 32'(bus.current_health[0 +: HW]), 32'd2);
    check("ch1dead", 32'(bus.no_health[1]), 32'd1);

    // Dead channel ignores adds; revive restores it.
    bus.enable = 1'b0;
    set_add(1, 10);
    step();
    clr_in();
    check("dead_add", 32'(bus.current_health[HW +: HW]), 32'd0);
    bus.revive[1] = 1'b1;
    step();
    clr_in();
    check("rev_h1", 32'(bus.current_health[HW +: HW]), 32'(INIT));
    check("rev_nh1", 32'(bus.no_health[1]), 32'd0);

    // Frozen prescaler: adds land, no decay.
    bus.health_rate = RW'(3);
    for (int c = 0; c < 50; c++) begin
      if (c == 10) set_add(0, 5);
      step();
      clr_in();
    end
    check("frz_h1", 32'(bus.current_health[HW +: HW]), 32'(INIT));
    bus.enable = 1'b1;
    repeat (6) step();

    // Reset mid-prescaler, then rate lowered below the running count.
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (9) step();
    bus.health_rate = RW'(7);
    repeat (5) step();
    bus.health_rate = RW'(1);
    repeat (4) step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      clr_in();
      if (c % 200 == 0)
        bus.health_rate = RW'($urandom_range(0, 3));
      bus.enable = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 15) == 0)
            set_add(i, $urandom_range(60, 127));
          else
            set_add(i, $urandom_range(0, 7));
        end
        if ($urandom_range(0, 63) == 0)
          bus.revive[i] = 1'b1;
      end
      step();
    end
    rst = 1'b0;
    clr_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got 0 want 1");
    $fatal(1, "timeout");
  end
endmodule
